memory_unit_ws: RTL and testbench
=================================

// Module: memory_unit_ws
// PURPOSE
//  Parametrised byte-lane data/instruction memory with a wait-state access sequencer.
//  Each request selects its address from PC, R6 or AluOut and reads or writes any subset of lanes.
//  Read data goes to the MDR (per lane) or to the IR (whole word).
//  Sits in the datapath between the control unit and the register file / ALU.
// PARAMETERS
//  DATA_W      16  word width; must be a multiple of LANE_W
//  LANE_W      8   byte-lane width; N_LANES = DATA_W/LANE_W
//  ADDR_W      8   word-address width; depth = 2**ADDR_W words
//  WAIT_STATES 1   extra cycles between request accept and array access (0..15)
// PORTS
//  clock    in   1        rising-edge clock
//  reset    in   1        asynchronous, active-high reset
//  memRd    in   1        read request (sampled in IDLE only)
//  memWr    in   1        write request (sampled in IDLE only)
//  addr_sel in   2        00 PC, 01 R6, 10 AluOut, 11 reserved (req rejected)
//  PC       in   DATA_W   address source 0 (low ADDR_W bits used)
//  R6       in   DATA_W   address source 1
//  AluOut   in   DATA_W   address source 2
//  wr_data  in   DATA_W   write data; lane k = bits [k*LANE_W +: LANE_W]
//  byte_en  in   N_LANES  lane enables for read-to-MDR and write
//  ir_wr    in   1        read destination: 1 = IR (whole word), 0 = MDR (enabled lanes)
//  busy     out  1        request in flight; new requests ignored
//  done     out  1        one-cycle pulse when the access completes
//  err      out  1        one-cycle pulse: request rejected
//  mdr      out  DATA_W   memory data register
//  ir       out  DATA_W   instruction register
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0, busy=0, done=0, err=0, mdr=0, ir=0; array NOT cleared.
//  States: IDLE -> WAIT -> ACCESS -> IDLE.
//  IDLE: on a clock edge with memRd^memWr=1 and addr_sel!=11:
//   - latch address (selected source[ADDR_W-1:0]), wr_data, byte_en, ir_wr, direction;
//   - load counter = WAIT_STATES; busy=1; go to WAIT (or ACCESS if WAIT_STATES=0).
//  Rejected requests (edge in IDLE): memRd&memWr=1, or addr_sel=11 with memRd|memWr=1.
//   - err pulses 1 cycle; state stays IDLE; no memory/MDR/IR change.
//  WAIT: counter decrements each cycle; at 0 go to ACCESS.
//  ACCESS: performed on the edge leaving ACCESS; done=1 and busy=0 the following cycle.
//   - Write: mem[a] lane k <= wr_data lane k for each byte_en[k]=1; other lanes unchanged.
//   - Read, ir_wr=1: ir <= mem[a] (all lanes, byte_en ignored); mdr unchanged.
//   - Read, ir_wr=0: mdr lane k <= mem[a] lane k for byte_en[k]=1; other mdr lanes hold.
//   - byte_en=0 with ir_wr=0: access completes (done pulses), nothing changes.
//  Latency: request edge n -> done high in cycle n+WAIT_STATES+2; busy high cycles n+1..n+WAIT_STATES+1.
//  While busy, memRd/memWr/addr_sel/wr_data/byte_en/ir_wr changes are ignored (latched copy used).
//  A new request may be accepted on the edge where done=1 (back-to-back, no idle bubble).
//  Address wrap: upper address bits above ADDR_W are discarded (address 2**ADDR_W aliases to 0).
//  Reset mid-operation: access aborted; an in-flight write is never committed; done is not pulsed.
//  Outputs mdr/ir/busy/done/err are registered; no combinational path from inputs to outputs.
// TESTING  (DATA_W=16, LANE_W=8, ADDR_W=8, WAIT_STATES=2 unless noted)
//  1 Write R6=1, byte_en=01, wr_data=0x0201; then write PC=2-source addr 1, byte_en=10, wr_data=0x0506
//    -> readback (ir_wr=1, addr 1) gives ir=0x0501; done 4 cycles after each request edge.
//  2 Read AluOut=3 after writing 0x0403 there, ir_wr=0, byte_en=10 with mdr=0
//    -> mdr=0x0400; a second read with byte_en=01 -> mdr=0x0403.
//  3 memRd&memWr=1, or addr_sel=11 -> err pulse, busy stays 0, memory/mdr/ir unchanged.
//  4 Toggle memWr and wr_data while busy -> only the latched request takes effect; one done pulse.
//  5 Assert reset during WAIT of a write of 0xBEEF to addr 7 (prior 0x1234)
//    -> busy=0, mdr=ir=0, readback of addr 7 = 0x1234.
//  6 WAIT_STATES=0, back-to-back reads from PC=0x0100 (aliases to 0) and 0
//    -> done in consecutive-request cadence of 2 cycles; both return mem[0].

Source files
------------

// File: rtl/memory_unit_ws.sv
// Byte-lane data/instruction memory with a wait-state access sequencer.
// Requests are latched in IDLE, held through WAIT, and performed on the edge leaving ACCESS.
module memory_unit_ws #(
    parameter int DATA_W      = 16,
    parameter int LANE_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       memRd,
    input  logic                       memWr,
    input  logic [1:0]                 addr_sel,
    input  logic [DATA_W-1:0]          PC,
    input  logic [DATA_W-1:0]          R6,
    input  logic [DATA_W-1:0]          AluOut,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/LANE_W-1:0]   byte_en,
    input  logic                       ir_wr,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [DATA_W-1:0]          mdr,
    output logic [DATA_W-1:0]          ir,
    output logic [1:0]                 dbg_state
);
    localparam int N_LANES = DATA_W / LANE_W;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]          wait_cnt;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_data;
    logic [N_LANES-1:0]  lat_be;
    logic                lat_ir;
    logic                lat_wr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                req_ok;
    logic                req_bad;
    logic [ADDR_W-1:0]   sel_addr;

    // Exactly one direction and a real address source make a request acceptable.
    assign req_ok  = (memRd ^ memWr) && (addr_sel != 2'b11);
    assign req_bad = (memRd | memWr) && !req_ok;

    always_comb begin
        sel_addr = PC[ADDR_W-1:0];
        case (addr_sel)
            2'b01:   sel_addr = R6[ADDR_W-1:0];
            2'b10:   sel_addr = AluOut[ADDR_W-1:0];
            default: sel_addr = PC[ADDR_W-1:0];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_ok)
                    state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            end
            // Counter reaches zero on the same edge that enters ACCESS.
            S_WAIT: begin
                if (wait_cnt <= 4'd1)
                    state_nxt = S_ACCESS;
            end
            S_ACCESS: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mdr      <= '0;
            ir       <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_be   <= '0;
            lat_ir   <= 1'b0;
            lat_wr   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            done  <= (state == S_ACCESS);
            err   <= (state == S_IDLE) && req_bad;

            if (state == S_IDLE && req_ok) begin
                lat_addr <= sel_addr;
                lat_data <= wr_data;
                lat_be   <= byte_en;
                lat_ir   <= ir_wr;
                lat_wr   <= memWr;
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (state == S_ACCESS && !lat_wr) begin
                if (lat_ir) begin
                    ir <= mem[lat_addr];
                end else begin
                    for (int k = 0; k < N_LANES; k++)
                        if (lat_be[k])
                            mdr[k*LANE_W +: LANE_W] <= mem[lat_addr][k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // The array is never reset; an aborted write cannot reach it because reset forces IDLE.
    always_ff @(posedge clock) begin
        if (state == S_ACCESS && lat_wr) begin
            for (int k = 0; k < N_LANES; k++)
                if (lat_be[k])
                    mem[lat_addr][k*LANE_W +: LANE_W] <= lat_data[k*LANE_W +: LANE_W];
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_memory_unit_ws.sv
// Bench for memory_unit_ws: directed scenarios plus randomized requests checked
// against an array-based reference memory; a second instance covers zero wait states.
module tb_memory_unit_ws;
    localparam int WS = 2;

    logic        clock;
    logic        reset;
    logic        memRd, memWr, ir_wr;
    logic [1:0]  addr_sel, byte_en;
    logic [15:0] PC, R6, AluOut, wr_data;
    logic        busy, done, err;
    logic [15:0] mdr, ir;
    logic [1:0]  dbg_state;

    logic        memRd_z, memWr_z, ir_wr_z;
    logic [1:0]  addr_sel_z, byte_en_z;
    logic [15:0] PC_z, R6_z, AluOut_z, wr_data_z;
    logic        busy_z, done_z, err_z;
    logic [15:0] mdr_z, ir_z;
    logic [1:0]  dbg_state_z;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem_m [256];
    logic [15:0] mdr_m, ir_m;

    memory_unit_ws #(.DATA_W(16), .LANE_W(8), .ADDR_W(8), .WAIT_STATES(WS)) dut (
        .clock(clock), .reset(reset), .memRd(memRd), .memWr(memWr), .addr_sel(addr_sel),
        .PC(PC), .R6(R6), .AluOut(AluOut), .wr_data(wr_data), .byte_en(byte_en),
        .ir_wr(ir_wr), .busy(busy), .done(done), .err(err), .mdr(mdr), .ir(ir),
        .dbg_state(dbg_state)
    );

    memory_unit_ws #(.DATA_W(16), .LANE_W(8), .ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset), .memRd(memRd_z), .memWr(memWr_z), .addr_sel(addr_sel_z),
        .PC(PC_z), .R6(R6_z), .AluOut(AluOut_z), .wr_data(wr_data_z), .byte_en(byte_en_z),
        .ir_wr(ir_wr_z), .busy(busy_z), .done(done_z), .err(err_z), .mdr(mdr_z), .ir(ir_z),
        .dbg_state(dbg_state_z)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic go_idle();
        memRd = 1'b0;
        memWr = 1'b0;
    endtask

    // One request, start to finish, with the model updated when it completes.
    task automatic do_req(input logic rd, input logic wr, input logic [1:0] sel,
                          input logic [15:0] a_val, input logic [15:0] d,
                          input logic [1:0] be, input logic irw, input bit scramble);
        logic [7:0] a;
        bit         rej;
        bit         seen;
        int         cyc;
        a   = a_val[7:0];
        rej = (rd && wr) || (sel == 2'b11 && (rd || wr));
        @(negedge clock);
        memRd = rd; memWr = wr; addr_sel = sel;
        PC = 16'($urandom); R6 = 16'($urandom); AluOut = 16'($urandom);
        case (sel)
            2'b00: PC = a_val;
            2'b01: R6 = a_val;
            2'b10: AluOut = a_val;
            default: ;
        endcase
        wr_data = d; byte_en = be; ir_wr = irw;
        @(negedge clock);
        go_idle();
        if (rej) begin
            check("err_pulse", {31'd0, err}, 32'd1);
            check("rej_busy", {31'd0, busy}, 32'd0);
            @(negedge clock);
            check("err_len", {31'd0, err}, 32'd0);
            check("rej_mdr", {16'd0, mdr}, {16'd0, mdr_m});
            check("rej_ir", {16'd0, ir}, {16'd0, ir_m});
            return;
        end
        cyc  = 1;
        seen = 1'b0;
        while (cyc < 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            check("busy_hold", {31'd0, busy}, 32'd1);
            if (scramble) begin
                memRd = 1'($urandom); memWr = 1'($urandom);
                addr_sel = 2'($urandom); wr_data = 16'($urandom);
                byte_en = 2'($urandom); ir_wr = 1'($urandom);
                PC = 16'($urandom); R6 = 16'($urandom); AluOut = 16'($urandom);
            end
            @(negedge clock);
            cyc++;
        end
        go_idle();
        check("done_seen", {31'd0, seen}, 32'd1);
        check("latency", cyc, WS + 2);
        check("busy_end", {31'd0, busy}, 32'd0);
        if (wr) begin
            for (int k = 0; k < 2; k++)
                if (be[k]) mem_m[a][k*8 +: 8] = d[k*8 +: 8];
        end else if (irw) begin
            ir_m = mem_m[a];
        end else begin
            for (int k = 0; k < 2; k++)
                if (be[k]) mdr_m[k*8 +: 8] = mem_m[a][k*8 +: 8];
        end
        check("mdr", {16'd0, mdr}, {16'd0, mdr_m});
        check("ir", {16'd0, ir}, {16'd0, ir_m});
        @(negedge clock);
        check("done_once", {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        memRd = 0; memWr = 0; addr_sel = 0; PC = 0; R6 = 0; AluOut = 0;
        wr_data = 0; byte_en = 0; ir_wr = 0;
        memRd_z = 0; memWr_z = 0; addr_sel_z = 0; PC_z = 0; R6_z = 0; AluOut_z = 0;
        wr_data_z = 0; byte_en_z = 0; ir_wr_z = 0;
        mdr_m = 16'h0; ir_m = 16'h0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mdr", {16'd0, mdr}, 32'd0);
        check("rst_ir", {16'd0, ir}, 32'd0);
        check("rst_busy_z", {31'd0, busy_z}, 32'd0);

        // Lane-merged writes to address 1 via two different sources.
        do_req(0, 1, 2'b01, 16'h0001, 16'h0201, 2'b01, 0, 0);
        do_req(0, 1, 2'b00, 16'h0001, 16'h0506, 2'b10, 0, 0);
        do_req(1, 0, 2'b00, 16'h0001, 16'h0000, 2'b00, 1, 0);
        check("t1_ir", {16'd0, ir}, 32'h0501);

        // Per-lane MDR loads.
        do_req(0, 1, 2'b10, 16'h0003, 16'h0403, 2'b11, 0, 0);
        do_req(1, 0, 2'b10, 16'h0003, 16'h0000, 2'b10, 0, 0);
        check("t2_mdr_hi", {16'd0, mdr}, 32'h0400);
        do_req(1, 0, 2'b10, 16'h0003, 16'h0000, 2'b01, 0, 0);
        check("t2_mdr_lo", {16'd0, mdr}, 32'h0403);

        // Rejected requests leave memory untouched.
        do_req(1, 1, 2'b00, 16'h0001, 16'hFFFF, 2'b11, 0, 0);
        do_req(0, 1, 2'b11, 16'h0001, 16'hFFFF, 2'b11, 0, 0);
        do_req(1, 0, 2'b11, 16'h0001, 16'hFFFF, 2'b11, 1, 0);
        do_req(1, 0, 2'b01, 16'h0001, 16'h0000, 2'b00, 1, 0);
        check("t3_mem", {16'd0, ir}, 32'h0501);

        // Inputs churn while busy; only the latched write lands.
        do_req(0, 1, 2'b00, 16'h0020, 16'hCAFE, 2'b11, 0, 1);
        do_req(1, 0, 2'b00, 16'h0020, 16'h0000, 2'b00, 1, 0);
        check("t4_ir", {16'd0, ir}, 32'hCAFE);

        // Reset during WAIT aborts the write.
        do_req(0, 1, 2'b10, 16'h0007, 16'h1234, 2'b11, 0, 0);
        @(negedge clock);
        memWr = 1; addr_sel = 2'b10; AluOut = 16'h0007; wr_data = 16'hBEEF; byte_en = 2'b11; ir_wr = 0;
        @(negedge clock);
        go_idle();
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_mdr", {16'd0, mdr}, 32'd0);
        check("t5_ir", {16'd0, ir}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        mdr_m = 16'h0; ir_m = 16'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t5_no_done", {31'd0, done}, 32'd0);
        end
        do_req(1, 0, 2'b10, 16'h0107, 16'h0000, 2'b00, 1, 0);
        check("t5_readback", {16'd0, ir}, 32'h1234);

        // Fill the whole array, then random traffic.
        for (int i = 0; i < 256; i++)
            do_req(0, 1, 2'($urandom_range(0, 2)), 16'(i), 16'($urandom), 2'b11, 0, 0);
        for (int i = 0; i < 250; i++) begin
            int op;
            logic [1:0] sel;
            op  = $urandom_range(0, 9);
            sel = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_req(op == 0 || op >= 5, op <= 4, sel, 16'($urandom), 16'($urandom),
                   2'($urandom), 1'($urandom), (i % 7) == 0);
        end

        // Zero wait states: back-to-back reads, upper address bits discarded.
        @(negedge clock);
        memWr_z = 1; addr_sel_z = 2'b00; PC_z = 16'h0000; wr_data_z = 16'hA5C3; byte_en_z = 2'b11; ir_wr_z = 0;
        @(negedge clock);
        check("t6_busy_w", {31'd0, busy_z}, 32'd1);
        memWr_z = 0; memRd_z = 1; PC_z = 16'h0100; ir_wr_z = 1;
        @(negedge clock);
        check("t6_done_w", {31'd0, done_z}, 32'd1);
        @(negedge clock);
        check("t6_busy_r1", {31'd0, busy_z}, 32'd1);
        check("t6_done_low", {31'd0, done_z}, 32'd0);
        PC_z = 16'h0000; ir_wr_z = 0; byte_en_z = 2'b11;
        @(negedge clock);
        check("t6_done_r1", {31'd0, done_z}, 32'd1);
        check("t6_ir", {16'd0, ir_z}, 32'hA5C3);
        @(negedge clock);
        check("t6_busy_r2", {31'd0, busy_z}, 32'd1);
        memRd_z = 0;
        @(negedge clock);
        check("t6_done_r2", {31'd0, done_z}, 32'd1);
        check("t6_mdr", {16'd0, mdr_z}, 32'hA5C3);
        @(negedge clock);
        check("t6_idle", {31'd0, busy_z | done_z}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
